// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter.
// Optional feature macro I2S_TX_UNDERFLOW_CNT_EN is consumed by i2s_tx.
package i2s_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned FRAME_SLOTS = 64;
  localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
  localparam int unsigned STEREO_W    = 2 * SAMPLE_W;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  // Slots that carry sample bits: 1..16 (left) and 33..48 (right).
  function automatic logic is_data_slot(input logic [SLOT_W-1:0] slot);
    return ((slot >= SLOT_W'(1)) && (slot <= SLOT_W'(SAMPLE_W))) ||
           ((slot >= SLOT_W'(SLOT_BITS + 1)) && (slot <= SLOT_W'(SLOT_BITS + SAMPLE_W)));
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO: registered level and ready, no fall-through.
// A push is refused while full, even when a pop happens in the same cycle.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  logic [STEREO_W-1:0]     i_push_data,
  input  logic                    i_pop,
  output logic [STEREO_W-1:0]     o_pop_data_c,
  output logic                    o_full_c,
  output logic                    o_empty_c,
  output logic                    o_ready,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  stereo_sample_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_do_push    = i_push && !w_full;
  assign w_do_pop     = i_pop && !w_empty;
  assign w_count_next = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // Pointers, occupancy and the look-ahead ready flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_do_push) begin
      r_mem[r_wr_ptr] <= stereo_sample_t'(i_push_data);
    end
  end

  assign o_pop_data_c = r_mem[r_rd_ptr];
  assign o_full_c     = w_full;
  assign o_empty_c    = w_empty;
  assign o_ready      = r_ready;
  assign o_level      = r_count;

endmodule

// File: rtl/i2s_tx.sv
// Stereo Philips-I2S transmitter: sample FIFO, BCLK divider, 64-slot framer.
// Define I2S_TX_UNDERFLOW_CNT_EN to enable the saturating underflow counter.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [STEREO_W-1:0]          s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         enable,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underflow,
  input  logic                         count_clr,
  output logic [15:0]                  underflow_count,
  output logic                         i2s_bclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_dout
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);

  i2s_state_e          r_state;
  logic [DIV_W-1:0]    r_div;
  logic [SLOT_W-1:0]   r_slot;
  logic [STEREO_W-1:0] r_shift;
  logic                r_bclk;
  logic                r_lrclk;
  logic                r_dout;
  logic                r_underflow;

  i2s_state_e          w_state_next;
  logic [DIV_W-1:0]    w_div_next;
  logic [SLOT_W-1:0]   w_slot_next;
  logic [STEREO_W-1:0] w_shift_next;
  logic                w_bclk_next;
  logic                w_lrclk_next;
  logic                w_dout_next;
  logic                w_underflow_next;
  logic                w_frame_start;
  logic                w_slot_adv;
  logic                w_div_wrap;

  logic                w_fifo_push;
  logic                w_fifo_pop;
  logic [STEREO_W-1:0] w_fifo_data;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_fifo_ready;

  assign w_fifo_push = s_valid && w_fifo_ready && !w_fifo_full;

  i2s_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_fifo_push),
    .i_push_data  (s_data),
    .i_pop        (w_fifo_pop),
    .o_pop_data_c (w_fifo_data),
    .o_full_c     (w_fifo_full),
    .o_empty_c    (w_fifo_empty),
    .o_ready      (w_fifo_ready),
    .o_level      (fifo_level)
  );

  assign w_div_wrap = (r_div == DIV_W'(BCLK_DIV - 1));

  // Next state, counters and next values of every registered pin.
  always_comb begin
    w_state_next     = r_state;
    w_div_next       = r_div;
    w_slot_next      = r_slot;
    w_shift_next     = r_shift;
    w_frame_start    = 1'b0;
    w_slot_adv       = 1'b0;
    w_fifo_pop       = 1'b0;
    w_underflow_next = 1'b0;
    w_bclk_next      = 1'b0;
    w_lrclk_next     = 1'b0;
    w_dout_next      = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next  = RUN;
          w_div_next    = '0;
          w_slot_next   = '0;
          w_frame_start = 1'b1;
        end
      end
      RUN: begin
        if (w_div_wrap) begin
          w_div_next = '0;
          if (r_slot == SLOT_W'(FRAME_SLOTS - 1)) begin
            w_slot_next = '0;
            if (enable) begin
              w_frame_start = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_slot_next = r_slot + SLOT_W'(1);
            w_slot_adv  = 1'b1;
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Slot 0 entry reloads the shifter; an empty FIFO substitutes silence.
    w_fifo_pop       = w_frame_start && !w_fifo_empty;
    w_underflow_next = w_frame_start && w_fifo_empty;

    if (w_frame_start) begin
      w_shift_next = w_fifo_empty ? '0 : w_fifo_data;
    end else if (w_slot_adv && is_data_slot(w_slot_next)) begin
      w_dout_next  = r_shift[STEREO_W-1];
      w_shift_next = r_shift << 1;
    end else if ((r_state == RUN) && !w_div_wrap) begin
      w_dout_next = r_dout;
    end

    if (w_state_next == RUN) begin
      w_bclk_next  = (w_div_next >= DIV_W'(BCLK_DIV / 2));
      w_lrclk_next = w_slot_next[SLOT_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_slot      <= '0;
      r_shift     <= '0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_dout      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_div       <= w_div_next;
      r_slot      <= w_slot_next;
      r_shift     <= w_shift_next;
      r_bclk      <= w_bclk_next;
      r_lrclk     <= w_lrclk_next;
      r_dout      <= w_dout_next;
      r_underflow <= w_underflow_next;
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_count;

  // Counts on the same edge that raises the pulse; clear takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_underflow_count <= '0;
    end else if (count_clr) begin
      r_underflow_count <= '0;
    end else if (w_underflow_next && (r_underflow_count != 16'hFFFF)) begin
      r_underflow_count <= r_underflow_count + 16'd1;
    end
  end

  assign underflow_count = r_underflow_count;
`else
  logic w_count_clr_unused;

  assign w_count_clr_unused = count_clr;
  assign underflow_count    = '0;
`endif

  assign s_ready   = w_fifo_ready;
  assign underflow = r_underflow;
  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_dout  = r_dout;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: FIFO fill table, frame capture on BCLK rise,
// underflow timing, enable drop, mid-frame reset and counter clear.
module tb_i2s_tx;

  localparam int unsigned BCLK_DIV   = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CAP_N      = 4096;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        exp_ready;
    logic [3:0]  exp_level;
  } fill_vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        enable = 1'b0;
  logic [3:0]  fifo_level;
  logic        underflow;
  logic        count_clr = 1'b0;
  logic [15:0] underflow_count;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx #(
    .BCLK_DIV   (BCLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .enable          (enable),
    .fifo_level      (fifo_level),
    .underflow       (underflow),
    .count_clr       (count_clr),
    .underflow_count (underflow_count),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_dout        (i2s_dout)
  );

  // Codec-side monitor: latch dout/lrclk at every BCLK rise.
  logic   cap_dout [CAP_N];
  logic   cap_lr   [CAP_N];
  int     cap_idx   = 0;
  int     uf_n      = 0;
  int     dout_ones = 0;
  longint uf_time [16];
  longint cyc       = 0;
  logic   prev_bclk = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (i2s_bclk && !prev_bclk) begin
      if (cap_idx < int'(CAP_N)) begin
        cap_dout[cap_idx] = i2s_dout;
        cap_lr[cap_idx]   = i2s_lrclk;
      end
      cap_idx = cap_idx + 1;
    end
    prev_bclk = i2s_bclk;
    if (underflow) begin
      uf_time[uf_n % 16] = cyc;
      uf_n = uf_n + 1;
    end
    if (i2s_dout) dout_ones = dout_ones + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_caps(input int target, input int limit, input string name);
    int n;
    n = 0;
    while ((cap_idx < target) && (n < limit)) begin
      step();
      n = n + 1;
    end
    if (cap_idx < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s timeout: captured %0d slots, needed %0d", name, cap_idx, target);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction

  // Reassemble one captured frame starting at slot-0 index b.
  task automatic check_frame(input string name, input int b, input logic [31:0] exp_word);
    logic [31:0] w;
    logic [63:0] lv;
    logic        other;
    w     = '0;
    lv    = '0;
    other = 1'b0;
    for (int s = 0; s < 64; s++) begin
      lv[s] = cap_lr[b + s];
      if (s >= 1 && s <= 16)       w[32 - s] = cap_dout[b + s];
      else if (s >= 33 && s <= 48) w[48 - s] = cap_dout[b + s];
      else                         other = other | cap_dout[b + s];
    end
    check({name, "_word"}, 64'(w), 64'(exp_word));
    check({name, "_idle_slots"}, 64'(other), 64'd0);
    check({name, "_lrclk"}, lv, 64'hFFFF_FFFF_0000_0000);
  endtask

  initial begin
    fill_vec_t fv [9];
    int base;
    int c0;
    int uf0;
    int d0;
    int k;
    int n;

    fv[0] = '{32'hA5A5_3C3C, 1'b1, 4'd1};
    fv[1] = '{32'h8000_0001, 1'b1, 4'd2};
    fv[2] = '{32'hFFFF_0000, 1'b1, 4'd3};
    fv[3] = '{32'h1234_ABCD, 1'b1, 4'd4};
    fv[4] = '{32'h0001_8000, 1'b1, 4'd5};
    fv[5] = '{32'h7FFF_FFFF, 1'b1, 4'd6};
    fv[6] = '{32'h5555_AAAA, 1'b1, 4'd7};
    fv[7] = '{32'h0F0F_F0F0, 1'b1, 4'd8};
    fv[8] = '{32'hDEAD_BEEF, 1'b0, 4'd8};

    // Reset values
    repeat (3) step();
    check("rst_pins", 64'({i2s_bclk, i2s_lrclk, i2s_dout, underflow}), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_count", 64'(underflow_count), 64'd0);
    reset_n = 1'b1;
    step();
    check("ready_after_reset", 64'(s_ready), 64'd1);

    // Fill past capacity with the serializer idle
    for (int i = 0; i < 9; i++) begin
      check("fill_ready", 64'(s_ready), 64'(fv[i].exp_ready));
      s_valid = 1'b1;
      s_data  = fv[i].data;
      step();
      s_valid = 1'b0;
      check("fill_level", 64'(fifo_level), 64'(fv[i].exp_level));
    end
    check("idle_pins", 64'({i2s_bclk, i2s_lrclk, i2s_dout}), 64'd0);

    // Run 8 data frames and one underflow frame, drop enable at slot 20
    base = cap_idx;
    uf0  = uf_n;
    enable = 1'b1;
    k = 0;
    for (int j = 1; j <= 100; j++) begin
      step();
      if (i2s_bclk) begin
        k = j;
        break;
      end
    end
    check("first_bclk_rise", 64'(k), 64'd9);
    wait_caps(base + 64 * 8 + 21, 9000, "frame8_slot20");
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h1111_2222;
    step();
    s_valid = 1'b0;
    wait_caps(base + 64 * 9, 2000, "frame8_end");
    wait_steps(1500);
    check("slots_after_stop", 64'(cap_idx - base), 64'd576);
    check("stopped_pins", 64'({i2s_bclk, i2s_lrclk, i2s_dout}), 64'd0);
    check("no_pop_in_idle", 64'(fifo_level), 64'd1);
    check("uf_pulses_run1", 64'(uf_n - uf0), 64'd1);
    check("uf_count_run1", 64'(underflow_count), 64'(exp_cnt(1)));
    for (int f = 0; f < 9; f++) begin
      check_frame($sformatf("frame%0d", f), base + 64 * f, (f < 8) ? fv[f].data : 32'h0);
    end

    // Mid-frame reset with 3 words queued
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h0BAD_0000 + 32'(i);
      step();
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    wait_steps(300);
    check("queued_before_reset", 64'(fifo_level), 64'd3);
    reset_n = 1'b0;
    enable  = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_pins", 64'({i2s_bclk, i2s_lrclk, i2s_dout, underflow}), 64'd0);
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd0);
    check("midrst_count", 64'(underflow_count), 64'd0);
    step();
    check("midrst_ready_after", 64'(s_ready), 64'd1);
    wait_steps(20);
    check("midrst_stays_idle", 64'({i2s_bclk, i2s_lrclk, i2s_dout}), 64'd0);

    // Two frames from an empty FIFO
    uf0 = uf_n;
    d0  = dout_ones;
    c0  = cap_idx;
    enable = 1'b1;
    n = 0;
    while ((uf_n < uf0 + 2) && (n < 3000)) begin
      step();
      n = n + 1;
    end
    enable = 1'b0;
    check("empty_uf_pulses", 64'(uf_n - uf0), 64'd2);
    check("empty_uf_spacing", 64'(uf_time[(uf0 + 1) % 16] - uf_time[uf0 % 16]), 64'd1024);
    wait_steps(1200);
    check("empty_dout_zero", 64'(dout_ones - d0), 64'd0);
    check("empty_slots", 64'(cap_idx - c0), 64'd128);
    check("empty_uf_count", 64'(underflow_count), 64'(exp_cnt(2)));

    // Clear coincident with underflow, plus push/pop on an empty FIFO
    c0 = cap_idx;
    enable    = 1'b1;
    count_clr = 1'b1;
    s_valid   = 1'b1;
    s_data    = 32'hCAFE_F00D;
    step();
    count_clr = 1'b0;
    s_valid   = 1'b0;
    check("clr_uf_pulse", 64'(underflow), 64'd1);
    check("clr_wins", 64'(underflow_count), 64'd0);
    check("push_pop_empty_level", 64'(fifo_level), 64'd1);
    step();
    check("clr_uf_one_cycle", 64'(underflow), 64'd0);
    check("clr_count_hold", 64'(underflow_count), 64'd0);
    wait_caps(c0 + 64 + 49, 3000, "clr_frame1");
    enable = 1'b0;
    wait_caps(c0 + 128, 2000, "clr_frame1_end");
    wait_steps(100);
    check_frame("clr_frame0", c0, 32'h0);
    check_frame("clr_frame1", c0 + 64, 32'hCAFE_F00D);
    check("clr_final_count", 64'(underflow_count), 64'd0);
    check("clr_final_level", 64'(fifo_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter between the Nios II sample-producer path and the audio codec's DAC input. It buffers 32-bit stereo PCM words in a small FIFO and generates BCLK and LRCLK from the system clock. It serializes 16-bit left/right samples in Philips I2S format onto the codec data line. The codec control path (I2C, MCLK) is handled elsewhere; this block only drives the serial audio pins.

## Interface
- BCLK_DIV, 16: clk cycles per BCLK period; even, ≥4. At 50 MHz: BCLK 3.125 MHz, 64 slots/frame, fs ≈ 48.8 kHz.
- FIFO_DEPTH, 8: sample FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock (50 MHz). One clock only.
- reset_n  in  1  synchronous, active-low reset.
- s_data  in  32  stereo sample, {left[15:0], right[15:0]}, two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; transfer when s_valid & s_ready at a clk edge.
- enable  in  1  run the serial interface.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow  out  1  one-cycle pulse: frame started with an empty FIFO.
- count_clr  in  1  clears underflow_count.
- underflow_count  out  16  saturating underflow counter (see Configuration).
- i2s_bclk  out  1  bit clock to codec.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_dout  out  1  serial data to codec.

## Operation
- States: IDLE, RUN. Counters: div_cnt (0..BCLK_DIV-1), slot (0..63).
- IDLE: bclk, lrclk and dout held 0. FIFO still accepts pushes. When enable = 1, the next edge enters RUN with div_cnt = 0 and slot = 0.
- RUN: div_cnt increments each clk and wraps at BCLK_DIV-1. bclk = 0 for div_cnt < BCLK_DIV/2, else 1.
- Each div_cnt wrap to 0 is a falling BCLK edge. At that edge slot advances (63 wraps to 0), and lrclk and dout update in the same cycle that bclk goes low.
- lrclk = slot[5].
- dout per slot:
  - slot 1..16: left[16-slot], MSB first.
  - slot 33..48: right[48-slot].
  - All other slots: 0.
- Slot 0 entry (entering RUN, or 63 to 0 wrap): pop FIFO into the shift/hold register.
  - If the FIFO is empty, load 0x0000_0000 and pulse underflow.
- enable deasserted in RUN: the current frame completes. At the end of slot 63, return to IDLE instead of wrapping; outputs go to 0.
- FIFO: s_ready = !full. Push blocked when full, even if a pop occurs the same cycle. No fall-through: a push and a pop in the same cycle on an empty FIFO give an underflow, and the pushed word is stored. fifo_level is the registered count.
- Reset mid-operation: the next edge forces IDLE, flushes the FIFO, zeroes the counters, and sets every output to its reset value.

## Timing
- Reset values: i2s_bclk 0, i2s_lrclk 0, i2s_dout 0, underflow 0, fifo_level 0, underflow_count 0, s_ready 0. s_ready is 1 in the first cycle after reset_n goes high.
- All outputs are registered; no combinational path from inputs to outputs.
- Enable to first BCLK rise: 1 + BCLK_DIV/2 clk.
- Left MSB appears on i2s_dout at slot 1, which is BCLK_DIV clk after RUN entry.
- Frame = 64·BCLK_DIV clk.
- The codec samples dout and lrclk on BCLK rise, mid-slot, giving BCLK_DIV/2 clk of setup.
- Push to visible in fifo_level: 1 clk.

## Configuration
- I2S_TX_UNDERFLOW_CNT_EN defined: underflow_count increments on each underflow pulse and saturates at 0xFFFF. count_clr zeroes it next edge; clear wins over a simultaneous increment.
- Macro undefined: the port remains, tied to 0, and count_clr is ignored. The underflow pulse is unaffected.

## Structure
- Package i2s_pkg:
  - Constants SAMPLE_W = 16, SLOT_BITS = 32, FRAME_SLOTS = 64.
  - typedef stereo_sample_t: packed struct {left, right}.
  - typedef i2s_state_e: {IDLE, RUN}.
- Sub-module i2s_sample_fifo: synchronous FIFO with push, pop, full, empty and level. Top holds the divider, slot counter, FSM and shifter.

## Test plan
- Reset, push 0xA5A5_3C3C, enable=1:
  - dout slots 1–16 = 0xA5A5 MSB first, slots 33–48 = 0x3C3C.
  - Other slots 0; lrclk low for slots 0–31.
  - First bclk rise 9 clk after enable (BCLK_DIV = 16).
- Push 9 words with FIFO_DEPTH = 8 and enable = 0: s_ready goes low after 8 pushes, fifo_level = 8, and the 9th word is not accepted.
- Enable with an empty FIFO for 2 frames:
  - dout all 0.
  - underflow pulses twice, 1024 clk apart.
  - underflow_count = 2 with the macro defined, 0 without.
- enable dropped at slot 20: the frame finishes through slot 63, then bclk, lrclk and dout stay 0 and no further pop occurs.
- reset_n low for 1 cycle mid-frame with 3 words queued: the next edge gives all outputs 0 and fifo_level 0; the cycle after, s_ready = 1.
- count_clr asserted in the same cycle as an underflow with the macro defined: underflow_count = 0.
